// File: rtl/alu_pkg.sv
// Shared ALU opcodes, issue-FSM state encoding and instruction field layout.
package alu_pkg;

  localparam int DW   = 8;
  localparam int NREG = 8;
  localparam int AW   = 3;
  localparam int OPW  = 5;
  localparam int IW   = 20;

  // Instruction field offsets within the 20-bit instruction word
  localparam int IMM_SEL_BIT = 19;
  localparam int OP_LSB      = 14;
  localparam int RD_LSB      = 11;
  localparam int RS_LSB      = 8;
  localparam int IMM_LSB     = 0;

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_AND  = 5'h02;
  localparam logic [4:0] OP_OR   = 5'h03;
  localparam logic [4:0] OP_XOR  = 5'h04;
  localparam logic [4:0] OP_NOT  = 5'h05;
  localparam logic [4:0] OP_SHL  = 5'h06;
  localparam logic [4:0] OP_SHR  = 5'h07;
  localparam logic [4:0] OP_ROL  = 5'h08;
  localparam logic [4:0] OP_ROR  = 5'h09;
  localparam logic [4:0] OP_INC  = 5'h0A;
  localparam logic [4:0] OP_LDI  = 5'h0B;
  localparam logic [4:0] OP_RSV0 = 5'h0C;
  localparam logic [4:0] OP_RSV1 = 5'h0D;
  localparam logic [4:0] OP_RSV2 = 5'h0E;
  localparam logic [4:0] OP_DEC  = 5'h0F;
  localparam logic [4:0] OP_SBB  = 5'h10;
  localparam logic [4:0] OP_MAX  = 5'h10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_FIRE  = 3'd2,
    S_CAPT  = 3'd3,
    S_WB    = 3'd4
  } state_t;

  typedef struct packed {
    logic       imm_sel;
    logic [4:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [7:0] imm;
  } instr_t;

endpackage

// File: rtl/alu_issue_regfile8.sv
// 8x8 register file: one synchronous write port, three combinational read ports.
// Write lands on the clock edge; reads see the pre-write value until then.
module regfile8 #(
  parameter int DW   = 8,
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr0,
  output logic [DW-1:0] rdata0,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata2
);

  logic [DW-1:0] regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata0 = regs[raddr0];
  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/alu_issue.sv
// Issues one instruction to the external ALU: operand read, single enable pulse, capture, writeback.
// Latency 4 cycles accept-to-done, one instruction per 5 cycles; instr_ready is low while busy.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NREG = 8,
  parameter int OPW  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [IW-1:0]            instr,
  output logic [DW-1:0]            alu_a1,
  output logic [DW-1:0]            alu_a2,
  output logic [OPW-1:0]           alu_control,
  output logic                     alu_enable,
  input  logic [DW-1:0]            alu_o,
  input  logic [2:0]               alu_status,
  output logic                     done,
  output logic                     err,
  output logic                     carry,
  input  logic [$clog2(NREG)-1:0]  dbg_addr,
  output logic [DW-1:0]            dbg_data
);

  localparam int RAW = $clog2(NREG);

  state_t          state;
  instr_t          ins;
  logic [OPW-1:0]  op_q;
  logic [RAW-1:0]  rd_q;
  logic [RAW-1:0]  rs_q;
  logic [DW-1:0]   imm_q;
  logic            imm_sel_q;
  logic [DW-1:0]   o_q;
  logic [2:0]      status_q;
  logic [DW-1:0]   rd_data;
  logic [DW-1:0]   rs_data;
  logic            unused_status;

  assign ins           = instr_t'(instr);
  assign instr_ready   = (state == S_IDLE);
  assign unused_status = ^status_q[2:1];

  regfile8 #(.DW(DW), .NREG(NREG), .AW(RAW)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (state == S_WB),
    .waddr  (rd_q),
    .wdata  (o_q),
    .raddr0 (rd_q),
    .rdata0 (rd_data),
    .raddr1 (rs_q),
    .rdata1 (rs_data),
    .raddr2 (dbg_addr),
    .rdata2 (dbg_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      rs_q        <= '0;
      imm_q       <= '0;
      imm_sel_q   <= 1'b0;
      o_q         <= '0;
      status_q    <= '0;
      alu_a1      <= '0;
      alu_a2      <= '0;
      alu_control <= '0;
      alu_enable  <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      carry       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            op_q      <= ins.op;
            rd_q      <= ins.rd;
            rs_q      <= ins.rs;
            imm_q     <= ins.imm;
            imm_sel_q <= ins.imm_sel;
            // err is registered here so it is visible during the SETUP cycle
            err       <= (ins.op > OP_MAX);
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (op_q > OP_MAX) begin
            state <= S_IDLE;
          end else begin
            alu_a1      <= rd_data;
            alu_a2      <= imm_sel_q ? imm_q : rs_data;
            alu_control <= op_q;
            alu_enable  <= 1'b1;
            state       <= S_FIRE;
          end
        end
        S_FIRE: begin
          alu_enable <= 1'b0;
          state      <= S_CAPT;
        end
        S_CAPT: begin
          o_q      <= alu_o;
          status_q <= alu_status;
          done     <= 1'b1;
          state    <= S_WB;
        end
        S_WB: begin
          if (op_q == OP_ADD) carry <= status_q[0];
          state <= S_IDLE;
        end
        default: begin
          alu_enable <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue driving a behavioural model of the 8-bit ALU.
module tb_alu_issue;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [19:0] instr = '0;
  logic [7:0]  alu_a1, alu_a2;
  logic [4:0]  alu_control;
  logic        alu_enable;
  logic [7:0]  alu_o = '0;
  logic [2:0]  alu_status = '0;
  logic        done, err, carry;
  logic [2:0]  dbg_addr = '0;
  logic [7:0]  dbg_data;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_r [8];

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_a1(alu_a1), .alu_a2(alu_a2), .alu_control(alu_control),
    .alu_enable(alu_enable), .alu_o(alu_o), .alu_status(alu_status),
    .done(done), .err(err), .carry(carry), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // ALU model: result registered on a clock edge where enable is high; status = {neg, zero, carry}
  function automatic logic [10:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [4:0] c);
    logic [8:0] s;
    logic [7:0] o;
    logic       cy;
    s = '0; o = '0; cy = 1'b0;
    case (c)
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; o = s[7:0]; cy = s[8]; end
      OP_SUB: begin s = {1'b0, a} - {1'b0, b}; o = s[7:0]; cy = s[8]; end
      OP_AND: o = a & b;
      OP_OR:  o = a | b;
      OP_XOR: o = a ^ b;
      OP_NOT: o = ~a;
      OP_SHL: begin o = a << b[2:0]; cy = a[7]; end
      OP_SHR: begin o = a >> b[2:0]; cy = a[0]; end
      OP_LDI: o = b;
      default: o = 8'h00;
    endcase
    return {o[7], (o == 8'h00), cy, o};
  endfunction

  always @(posedge clk) begin
    if (alu_enable) {alu_status, alu_o} <= alu_f(alu_a1, alu_a2, alu_control);
  end

  function automatic logic [19:0] mk(input logic s, input logic [4:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs, input logic [7:0] imm);
    return {s, op, rd, rs, imm};
  endfunction

  task automatic exec(input logic [19:0] ins);
    for (int i = 0; i < 20 && instr_ready !== 1'b1; i++) @(negedge clk);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin cyc = i; break; end
    end
  endtask

  task automatic run(input logic [19:0] ins);
    int c;
    exec(ins);
    wait_done(c);
  endtask

  task automatic test_reset;
    logic bad;
    @(negedge clk);
    tests++; if ({instr_ready, alu_enable, done, err, carry} !== 5'b10000) begin
      fails++; $display("FAIL reset_ctrl got %b want 10000", {instr_ready, alu_enable, done, err, carry}); end
    tests++; if ({alu_a1, alu_a2, alu_control} !== 21'h0) begin
      fails++; $display("FAIL reset_bus got %h want 0", {alu_a1, alu_a2, alu_control}); end
    rst = 1'b0;
    @(negedge clk);
    exec(mk(1, OP_LDI, 3'd5, 3'd0, 8'h77));
    @(negedge clk);
    @(negedge clk);
    tests++; if (alu_enable !== 1'b1) begin
      fails++; $display("FAIL fire_before_reset got %b want 1", alu_enable); end
    rst = 1'b1;
    #1;
    tests++; if (alu_enable !== 1'b0) begin
      fails++; $display("FAIL reset_drops_enable got %b want 0", alu_enable); end
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) rst = 1'b0;
      if (done !== 1'b0 || err !== 1'b0) bad = 1'b1;
    end
    tests++; if (bad !== 1'b0) begin
      fails++; $display("FAIL reset_no_pulse got %b want 0", bad); end
    bad = 1'b0;
    for (int a = 0; a < 8; a++) begin
      dbg_addr = 3'(a);
      #1;
      if (dbg_data !== 8'h00) bad = 1'b1;
    end
    tests++; if (bad !== 1'b0) begin
      fails++; $display("FAIL reset_regs_zero got %b want 0", bad); end
    tests++; if (instr_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready got %b want 1", instr_ready); end
  endtask

  task automatic test_add_carry;
    int c;
    run(mk(1, OP_LDI, 3'd1, 3'd0, 8'hF0));
    dbg_addr = 3'd1;
    exec(mk(1, OP_ADD, 3'd1, 3'd0, 8'h20));
    @(negedge clk);
    @(negedge clk);
    tests++; if ({alu_enable, alu_a1, alu_a2, alu_control} !== {1'b1, 8'hF0, 8'h20, OP_ADD}) begin
      fails++; $display("FAIL add_operands got %h want %h", {alu_enable, alu_a1, alu_a2, alu_control},
                        {1'b1, 8'hF0, 8'h20, OP_ADD}); end
    wait_done(c);
    tests++; if (c !== 2) begin
      fails++; $display("FAIL add_done_cycle got c%0d want c4", c + 2); end
    tests++; if (dbg_data !== 8'hF0) begin
      fails++; $display("FAIL add_dbg_old got %h want f0", dbg_data); end
    @(negedge clk);
    tests++; if ({dbg_data, carry, done} !== {8'h10, 1'b1, 1'b0}) begin
      fails++; $display("FAIL add_result got %h want 120", {dbg_data, carry, done}); end
    run(mk(1, OP_OR, 3'd1, 3'd0, 8'h01));
    @(negedge clk);
    tests++; if ({dbg_data, carry} !== {8'h11, 1'b1}) begin
      fails++; $display("FAIL or_keeps_carry got %h want 111", {dbg_data, carry}); end
  endtask

  task automatic test_regops;
    run(mk(1, OP_LDI, 3'd2, 3'd0, 8'h0F));
    run(mk(1, OP_LDI, 3'd3, 3'd0, 8'h3C));
    run(mk(0, OP_XOR, 3'd2, 3'd3, 8'h00));
    @(negedge clk);
    dbg_addr = 3'd2; #1;
    tests++; if (dbg_data !== 8'h33) begin
      fails++; $display("FAIL xor_r2 got %h want 33", dbg_data); end
    dbg_addr = 3'd3; #1;
    tests++; if (dbg_data !== 8'h3C) begin
      fails++; $display("FAIL xor_r3_kept got %h want 3c", dbg_data); end
    exec(mk(0, OP_AND, 3'd3, 3'd3, 8'h00));
    @(negedge clk);
    @(negedge clk);
    tests++; if ({alu_a1, alu_a2} !== 16'h3C3C) begin
      fails++; $display("FAIL and_same_operands got %h want 3c3c", {alu_a1, alu_a2}); end
    repeat (3) @(negedge clk);
    tests++; if (dbg_data !== 8'h3C) begin
      fails++; $display("FAIL and_r3 got %h want 3c", dbg_data); end
  endtask

  task automatic test_back_to_back;
    logic [19:0] seq [3];
    int acc [$];
    int en [$];
    int n;
    logic took, bad;
    seq[0] = mk(1, OP_LDI, 3'd5, 3'd0, 8'h05);
    seq[1] = mk(1, OP_ADD, 3'd5, 3'd0, 8'h03);
    seq[2] = mk(0, OP_XOR, 3'd6, 3'd5, 8'h00);
    n = 0;
    @(negedge clk);
    instr = seq[0];
    instr_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      took = 1'b0;
      if (alu_enable === 1'b1) en.push_back(t);
      if (instr_valid && instr_ready === 1'b1) begin acc.push_back(t); n++; took = 1'b1; end
      @(posedge clk);
      #1;
      if (took) begin
        if (n < 3) instr = seq[n];
        else instr_valid = 1'b0;
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    tests++; if (acc.size() !== 3 || en.size() !== 3) begin
      fails++; $display("FAIL b2b_counts got acc=%0d en=%0d want 3 3", acc.size(), en.size()); end
    bad = 1'b0;
    if (acc.size() == 3 && en.size() == 3) begin
      if (acc[1] - acc[0] != 5 || acc[2] - acc[1] != 5) bad = 1'b1;
      for (int i = 0; i < 3; i++) if (en[i] != acc[i] + 2) bad = 1'b1;
    end else bad = 1'b1;
    tests++; if (bad !== 1'b0) begin
      fails++; $display("FAIL b2b_timing got %b want 0", bad); end
    dbg_addr = 3'd5; #1;
    tests++; if (dbg_data !== 8'h08) begin
      fails++; $display("FAIL b2b_r5 got %h want 08", dbg_data); end
    dbg_addr = 3'd6; #1;
    tests++; if ({dbg_data, carry} !== {8'h08, 1'b0}) begin
      fails++; $display("FAIL b2b_r6_carry got %h want 010", {dbg_data, carry}); end
  endtask

  task automatic test_illegal;
    logic bad;
    exp_r[0] = 8'h00; exp_r[1] = 8'h11; exp_r[2] = 8'h33; exp_r[3] = 8'h3C;
    exp_r[4] = 8'h00; exp_r[5] = 8'h08; exp_r[6] = 8'h08; exp_r[7] = 8'h00;
    exec(mk(1, 5'h15, 3'd1, 3'd0, 8'hFF));
    @(negedge clk);
    tests++; if ({err, alu_enable, instr_ready, done} !== 4'b1000) begin
      fails++; $display("FAIL illegal_c1 got %b want 1000", {err, alu_enable, instr_ready, done}); end
    @(negedge clk);
    tests++; if ({err, alu_enable, instr_ready, done} !== 4'b0010) begin
      fails++; $display("FAIL illegal_c2 got %b want 0010", {err, alu_enable, instr_ready, done}); end
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (alu_enable !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    for (int a = 0; a < 8; a++) begin
      dbg_addr = 3'(a); #1;
      if (dbg_data !== exp_r[a]) bad = 1'b1;
    end
    tests++; if (bad !== 1'b0) begin
      fails++; $display("FAIL illegal_no_effect got %b want 0", bad); end
  endtask

  task automatic test_shift_zero;
    int c;
    run(mk(1, OP_LDI, 3'd4, 3'd0, 8'h81));
    run(mk(1, OP_SHL, 3'd4, 3'd0, 8'h01));
    @(negedge clk);
    dbg_addr = 3'd4; #1;
    tests++; if (dbg_data !== 8'h02) begin
      fails++; $display("FAIL shl_r4 got %h want 02", dbg_data); end
    exec(mk(0, OP_RSV0, 3'd4, 3'd0, 8'h00));
    wait_done(c);
    tests++; if (c !== 4) begin
      fails++; $display("FAIL zero_op_done got %0d want 4", c); end
    @(negedge clk);
    tests++; if (dbg_data !== 8'h00) begin
      fails++; $display("FAIL zero_op_r4 got %h want 00", dbg_data); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_carry();
    test_regops();
    test_back_to_back();
    test_illegal();
    test_shift_zero();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
